// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I control encodings
// Purpose: instruction-class codes, opcodes, control-FSM states and
//          datapath mux select encodings used by the control unit and decoders.
package rv32i_pkg;

   // Instruction-class codes consumed by the immediate generator
   localparam logic [3:0] CLS_LOAD    = 4'd0;
   localparam logic [3:0] CLS_IMM     = 4'd1;
   localparam logic [3:0] CLS_STORE   = 4'd2;
   localparam logic [3:0] CLS_REG     = 4'd3;
   localparam logic [3:0] CLS_LUI     = 4'd4;
   localparam logic [3:0] CLS_AUIPC   = 4'd5;
   localparam logic [3:0] CLS_BRNCH   = 4'd6;
   localparam logic [3:0] CLS_JALR    = 4'd7;
   localparam logic [3:0] CLS_JAL     = 4'd8;
   localparam logic [3:0] CLS_ILLEGAL = 4'd15;

   // Major opcodes, inst[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_e;

   // ALU operand A / B selects
   localparam logic [1:0] SRC_A_RS1  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;
   localparam logic       SRC_B_RS2  = 1'b0;
   localparam logic       SRC_B_IMM  = 1'b1;

   // Register-file writeback selects
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // Next-PC selects
   localparam logic [1:0] PC_PLUS4     = 2'd0;
   localparam logic [1:0] PC_ALU       = 2'd1;
   localparam logic [1:0] PC_ALU_ALIGN = 2'd2;
   localparam logic [1:0] PC_RESET     = 2'd3;

endpackage

// File: rtl/inst_classify.sv
// rtl/inst_classify.sv - combinational RV32I opcode to instruction-class decode
// Purpose: map a major opcode onto the 4-bit class code; unknown opcodes map to ILLEGAL.
// Ports:   opcode_i - inst[6:0]
//          cls_o    - class code (see rv32i_pkg)
module inst_classify
   import rv32i_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [3:0] cls_o
);

   always_comb begin
      cls_o = CLS_ILLEGAL;
      case (opcode_i)
         OP_LOAD:   cls_o = CLS_LOAD;
         OP_IMM:    cls_o = CLS_IMM;
         OP_STORE:  cls_o = CLS_STORE;
         OP_REG:    cls_o = CLS_REG;
         OP_LUI:    cls_o = CLS_LUI;
         OP_AUIPC:  cls_o = CLS_AUIPC;
         OP_BRANCH: cls_o = CLS_BRNCH;
         OP_JALR:   cls_o = CLS_JALR;
         OP_JAL:    cls_o = CLS_JAL;
         default:   cls_o = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle RV32I control unit
// Purpose: sequence each instruction through FETCH/DECODE/EXEC/MEM/WB and drive
//          the datapath muxes, register-file write, PC update and memory handshakes.
// Ports:   clk, rst (sync, active-high)
//          inst, br_taken, imem_ready, dmem_ready      - datapath / memory status
//          imem_req, ir_we, dmem_req, dmem_we           - memory handshakes
//          imm_type, alu_src_a, alu_src_b, alu_op       - decode / ALU controls
//          rf_we, wb_sel, pc_we, pc_sel                 - writeback and PC update
//          illegal, instret                             - sticky trap flag, retire count
module ctrl_fsm
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             br_taken,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_we,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [3:0]       imm_type,
   output logic [1:0]       alu_src_a,
   output logic             alu_src_b,
   output logic [3:0]       alu_op,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_e           state_q, state_d;
   logic [3:0]       cls_q, cls_d;
   logic [3:0]       dec_cls;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   // RESET_PC is applied by the datapath; only the select lives here.
   logic unused_bits;
   assign unused_bits = ^{inst[31], inst[29:15], inst[11:7], RESET_PC};

   inst_classify u_classify (
      .opcode_i (inst[6:0]),
      .cls_o    (dec_cls)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         cls_q     <= CLS_ILLEGAL;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      illegal_d = illegal_q;
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      imm_type  = 4'd0;
      alu_src_a = SRC_A_RS1;
      alu_src_b = SRC_B_RS2;
      alu_op    = 4'd0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;

      // The class register is valid from EXEC until the instruction retires.
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
         imm_type = cls_q;
      end

      case (state_q)
         ST_INIT: begin
            pc_we   = 1'b1;
            pc_sel  = PC_RESET;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
            if (imem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            cls_d = dec_cls;
            if (dec_cls == CLS_ILLEGAL) begin
               state_d   = ST_TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (cls_q)
               CLS_LUI: begin
                  alu_src_a = SRC_A_ZERO;
                  alu_src_b = SRC_B_IMM;
               end
               CLS_AUIPC, CLS_JAL, CLS_BRNCH: begin
                  alu_src_a = SRC_A_PC;
                  alu_src_b = SRC_B_IMM;
               end
               CLS_REG: begin
                  alu_op = {inst[30], inst[14:12]};
               end
               CLS_IMM: begin
                  alu_src_b = SRC_B_IMM;
                  alu_op    = {inst[30], inst[14:12]};
               end
               default: begin
                  alu_src_b = SRC_B_IMM;
               end
            endcase
            if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
               state_d = ST_MEM;
            end else if (cls_q == CLS_BRNCH) begin
               pc_we   = 1'b1;
               pc_sel  = br_taken ? PC_ALU : PC_PLUS4;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == CLS_STORE);
            if (dmem_ready) begin
               if (cls_q == CLS_STORE) begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_PLUS4;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_FETCH;
            if (cls_q == CLS_LOAD) begin
               wb_sel = WB_MEM;
            end else if (cls_q == CLS_JAL || cls_q == CLS_JALR) begin
               wb_sel = WB_PC4;
            end
            if (cls_q == CLS_JAL) begin
               pc_sel = PC_ALU;
            end else if (cls_q == CLS_JALR) begin
               pc_sel = PC_ALU_ALIGN;
            end
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Every PC write outside INIT retires exactly one instruction.
      instret_d = instret_q;
      if (pc_we && state_q != ST_INIT) begin
         instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      // Reset quiesces every output, abandoning any outstanding request.
      if (rst) begin
         imem_req  = 1'b0;
         ir_we     = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         imm_type  = 4'd0;
         alu_src_a = 2'd0;
         alu_src_b = 1'b0;
         alu_op    = 4'd0;
         rf_we     = 1'b0;
         wb_sel    = 2'd0;
         pc_we     = 1'b0;
         pc_sel    = 2'd0;
      end
   end

   assign illegal = rst ? 1'b0 : illegal_q;
   assign instret = rst ? '0 : instret_q;

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Multi-cycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It decodes the opcode into the 4-bit instruction-class code consumed by the immediate generator, and drives the datapath muxes, register-file write, PC update and the instruction/data memory handshakes. It sits beside the datapath and reads the instruction register the datapath holds.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into the PC when pc_sel=3 during reset recovery
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
inst  in  32  current instruction register contents
br_taken  in  1  branch comparator result, valid in EXEC
imem_ready  in  1  instruction memory has data this cycle
dmem_ready  in  1  data memory access completes this cycle
imem_req  out  1  instruction fetch request
ir_we  out  1  load instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
imm_type  out  4  class code to immediate generator
alu_src_a  out  2  0=rs1, 1=PC, 2=zero
alu_src_b  out  1  0=rs2, 1=imm
alu_op  out  4  {funct7[5],funct3} for reg/imm; 4'b0000 (add) otherwise
rf_we  out  1  register-file write enable
wb_sel  out  2  0=ALU, 1=load data, 2=PC+4
pc_we  out  1  PC write enable
pc_sel  out  2  0=PC+4, 1=ALU result (branch/jal), 2=ALU result & ~1 (jalr), 3=RESET_PC
illegal  out  1  sticky illegal-instruction flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- Class codes: load 0, imm 1, store 2, reg 3, lui 4, auipc 5, brnch 6, jalr 7, jal 8, illegal 15.
- Opcode map, inst[6:0]:
  - 0000011→0, 0010011→1, 0100011→2, 0110011→3, 0110111→4.
  - 0010111→5, 1100011→6, 1100111→7, 1101111→8.
  - Anything else → 15.
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, TRAP. State register and class register are updated on posedge clk only.
- rst=1 (any state, including mid-wait): next state INIT, class=15, illegal=0, instret=0. All outputs are 0 while rst=1. Any outstanding memory request is abandoned.
- INIT: pc_we=1, pc_sel=3. Next state FETCH.
- FETCH: imem_req=1, held until imem_ready. ir_we = imem_ready. On imem_ready go to DECODE, else stay.
- DECODE:
  - Register class from inst[6:0].
  - If class=15 go to TRAP, else go to EXEC.
  - imm_type shows the registered class from EXEC onward.
- EXEC: set ALU controls per class.
  - lui: a=zero, b=imm.
  - auipc, jal, brnch: a=PC, b=imm.
  - reg: a=rs1, b=rs2.
  - load, store, imm, jalr: a=rs1, b=imm.
  - Next state:
    - load/store → MEM.
    - brnch → FETCH, with pc_we=1 and pc_sel = br_taken ? 1 : 0.
    - all others → WB.
- MEM: dmem_req=1, dmem_we=(class==store), held until dmem_ready.
  - On dmem_ready, store → FETCH with pc_we=1, pc_sel=0.
  - On dmem_ready, load → WB.
- WB: rf_we=1, pc_we=1.
  - wb_sel: load=1, jal/jalr=2, else 0.
  - pc_sel: jal=1, jalr=2, else 0.
  - Next state FETCH.
- instret increments by 1 on each cycle with pc_we=1 outside INIT. It wraps modulo 2^CNT_W.
- TRAP: illegal=1, all other enables 0. Held until rst.
- Latency with zero-wait memory:
  - brnch: 3 cycles.
  - reg, imm, lui, auipc, jal, jalr: 4 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
  - Each wait cycle adds 1.
- imem_req and dmem_req never overlap. Requests stay asserted and stable until ready.

Decomposition:
- Package rv32i_pkg holds:
  - class-code constants (LOAD..JAL, ILLEGAL=15)
  - opcode constants
  - state encoding
  - alu_src/wb_sel/pc_sel encodings
- One sub-module, inst_classify: combinational opcode→class. Shared later with a pipelined decoder.

Test Plan:
- rst held 2 cycles, then released, zero-wait memories → INIT pc_we=1 pc_sel=3; then FETCH imem_req=1; all other outputs 0, instret=0.
- add x1,x2,x3 (0x003100B3), zero-wait → 4 cycles; EXEC alu_op=0000, a=0, b=0; WB rf_we=1, wb_sel=0; instret=1.
- lw (0x0000A083), dmem_ready delayed 3 cycles → MEM holds dmem_req=1, dmem_we=0 for 4 cycles; WB wb_sel=1; total 8 cycles.
- beq with br_taken=1, then with br_taken=0 → EXEC pc_we=1 with pc_sel=1, then pc_sel=0; rf_we never 1; imm_type=6.
- jalr (0x000100E7) → imm_type=7, WB wb_sel=2, pc_sel=2; then a 0x00000000 inst → TRAP, illegal=1 held 10 cycles.
- rst asserted during a FETCH wait → next cycle INIT, imem_req=0, illegal cleared.
